// File: rtl/lcd_strbuf_fmt_if.sv
// Host-side bus of the 2x16 string buffer: direct character writes, number
// format requests and the resulting status and string image.
interface lcd_strbuf_fmt_if #(
    parameter int unsigned NUM_W = 16
);
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [7:0]       wr_char;
    logic             num_start;
    logic [NUM_W-1:0] num_value;
    logic [4:0]       num_pos;
    logic             busy;
    logic             done;
    logic [255:0]     strdata;

    modport master (
        output wr_en, wr_addr, wr_char, num_start, num_value, num_pos,
        input  busy, done, strdata
    );

    modport slave (
        input  wr_en, wr_addr, wr_char, num_start, num_value, num_pos,
        output busy, done, strdata
    );
endinterface

// File: rtl/lcd_strbuf_fmt.sv
// 32-character string image for the 2x16 display, with a direct write port and
// a double-dabble formatter that renders an unsigned value as a decimal field.
module lcd_strbuf_fmt #(
    parameter int unsigned NUM_W     = 16,
    parameter int unsigned DIGITS    = 5,
    parameter bit          BLANK_LZ  = 1'b1,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic           CCLK,
    input  logic           reset,
    lcd_strbuf_fmt_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(NUM_W + DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [NUM_W-1:0]   shift_q, shift_d;
    logic [4:0]         pos_q, pos_d;
    logic               lz_q, lz_d;
    logic [255:0]       buf_q, buf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [3:0]         digit;
    logic               blank;
    logic [7:0]         ch;
    logic [7:0]         widx;
    logic [7:0]         didx;

    always_ff @(posedge CCLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            shift_q <= '0;
            pos_q   <= '0;
            lz_q    <= 1'b0;
            buf_q   <= {32{FILL_CHAR}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            pos_q   <= pos_d;
            lz_q    <= lz_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        pos_d   = pos_q;
        lz_d    = lz_q;
        buf_d   = buf_q;
        bcd_adj = bcd_q;
        digit   = bcd_q[BCD_W-1 -: 4];
        blank   = 1'b0;
        ch      = 8'h20;
        widx    = 8'd255 - {bus.wr_addr, 3'b000};
        didx    = 8'd255 - {pos_q, 3'b000};

        // Direct write first so a same-edge digit write to that char overrides it
        if (bus.wr_en) begin
            buf_d[widx -: 8] = bus.wr_char;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.num_start) begin
                    shift_d = bus.num_value;
                    pos_d   = bus.num_pos;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    lz_d    = 1'b1;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (bcd_adj[4*i +: 4] >= 4'd5) begin
                        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
                    end
                end
                {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                if (cnt_q == CNT_W'(NUM_W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                // Blank only while every higher digit was zero; the units digit always shows
                blank = BLANK_LZ && lz_q && (digit == 4'd0)
                        && (cnt_q != CNT_W'(DIGITS - 1));
                ch    = blank ? 8'h20 : (8'h30 + {4'h0, digit});
                buf_d[didx -: 8] = ch;
                bcd_d = {bcd_q[BCD_W-5:0], 4'h0};
                lz_d  = lz_q && (digit == 4'd0);
                pos_d = pos_q + 5'd1;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CONVERT) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.strdata = buf_q;
endmodule
